// File: rtl/run_detect_param.sv
// Run-length detector with a run-time length: flags runs of 0s or 1s lasting len samples,
// with overlapping or non-overlapping detection, a run-length readout and a match counter.
module run_detect_param #(
  parameter int unsigned LEN_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             en,
  input  logic             w,
  input  logic [LEN_W-1:0] len,
  input  logic             overlap,
  output logic             z,
  output logic             z0,
  output logic             z1,
  output logic             hit,
  output logic [LEN_W-1:0] run_cnt,
  output logic [CNT_W-1:0] match_cnt
);

  logic             last_q, last_d;
  logic             seen_q, seen_d;
  logic [LEN_W-1:0] run_q, run_d;
  logic [CNT_W-1:0] match_q, match_d;
  logic             z0_q, z0_d;
  logic             z1_q, z1_d;
  logic             hit_q, hit_d;

  logic [LEN_W-1:0] l_eff;
  logic [LEN_W-1:0] n;
  logic             m;

  always_comb begin
    l_eff = (len == '0) ? LEN_W'(1) : len;

    // A new polarity (or the very first sample) always restarts the run at 1.
    if (!seen_q || (w != last_q)) begin
      n = LEN_W'(1);
    end else if (run_q == '1) begin
      n = run_q;
    end else begin
      n = run_q + LEN_W'(1);
    end

    m = overlap ? (n >= l_eff) : (n == l_eff);

    last_d  = last_q;
    seen_d  = seen_q;
    run_d   = run_q;
    match_d = match_q;
    z0_d    = z0_q;
    z1_d    = z1_q;
    hit_d   = 1'b0;

    if (en) begin
      last_d  = w;
      seen_d  = 1'b1;
      // Clearing on a non-overlapping match makes the next equal sample count as 1.
      run_d   = (m && !overlap) ? '0 : n;
      match_d = match_q + CNT_W'(m);
      z0_d    = m & ~w;
      z1_d    = m & w;
      hit_d   = m;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      last_q  <= 1'b0;
      seen_q  <= 1'b0;
      run_q   <= '0;
      match_q <= '0;
      z0_q    <= 1'b0;
      z1_q    <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      last_q  <= last_d;
      seen_q  <= seen_d;
      run_q   <= run_d;
      match_q <= match_d;
      z0_q    <= z0_d;
      z1_q    <= z1_d;
      hit_q   <= hit_d;
    end
  end

  assign z         = z0_q | z1_q;
  assign z0        = z0_q;
  assign z1        = z1_q;
  assign hit       = hit_q;
  assign run_cnt   = run_q;
  assign match_cnt = match_q;

endmodule
